// File: rtl/keypad_emulator.sv
// keypad_emulator
// Behavioural-but-synthesizable 3x4 matrix keypad. Sits on the far side of the
// door-lock scanner: the lock drives columnSel, this block answers on scanData
// the way a physical keypad would. Presses are accepted one at a time over a
// valid/ready handshake. Each press is played out as contact bounce, a clean
// hold, release bounce and a release gap. A press counter records how many
// presses reached the clean hold phase.
//
// Key geometry: row = code / 3, col = code % 3
//   code  0..2  -> keys 1 2 3   (row 0)
//   code  3..5  -> keys 4 5 6   (row 1)
//   code  6..8  -> keys 7 8 9   (row 2)
//   code  9..11 -> keys * 0 #   (row 3)
//   code 12..15 -> not a key; flagged on invalid, no contact, no count
//
// Timeline of one valid press accepted on edge T0 (first busy cycle follows T0):
//   BOUNCE_IN  : BOUNCE_CYCLES cycles, contact = 1,0,1,0,...
//   HOLD       : HOLD_CYCLES cycles,   contact = 1 (press_count bumps on entry)
//   BOUNCE_OUT : BOUNCE_CYCLES cycles, contact = 0,1,0,1,...
//   GAP        : GAP_CYCLES cycles,    contact = 0
// Phases with a zero length are skipped entirely.

module keypad_emulator #(
  parameter int HOLD_CYCLES   = 16,  // 1..65535
  parameter int GAP_CYCLES    = 16,  // 0..65535
  parameter int BOUNCE_CYCLES = 4    // 0..255, 0 disables bounce
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [2:0] columnSel,
  output logic [3:0] scanData,
  output logic       busy,
  output logic       invalid,
  output logic [7:0] press_count
);

  // ---------------------------------------------------------------------------
  // Types and elaboration-time constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  // Terminal values of the per-phase cycle counter. A zero-length phase is
  // never entered, so its (wrapped) terminal value is never compared against.
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] BOUNCE_LAST = 16'(BOUNCE_CYCLES - 1);

  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 0);
  localparam bit HAS_GAP    = (GAP_CYCLES != 0);

  // Phase routing with zero-length phases folded out at elaboration time.
  localparam state_t AFTER_RELEASE = HAS_GAP    ? GAP        : IDLE;
  localparam state_t AFTER_HOLD    = HAS_BOUNCE ? BOUNCE_OUT : AFTER_RELEASE;
  localparam state_t PRESS_ENTRY   = HAS_BOUNCE ? BOUNCE_IN  : HOLD;

  localparam logic [3:0] FIRST_BAD_CODE = 4'd12;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;          // cycle index k within the current phase

  logic        contact_q, contact_d;  // registered "switch closed" bit
  logic        ready_q, ready_d;      // registered IDLE decode
  logic        invalid_q, invalid_d;
  logic [7:0]  count_q;
  logic        hold_entry;
  logic [3:0]  cur_code_q;

  logic        accept;
  logic        code_ok;

  logic [1:0]  key_row;
  logic [1:0]  key_col;

  // A key is taken only while idle; key_valid at any other time is ignored.
  assign accept  = key_valid && ready_q;
  assign code_ok = (key_code < FIRST_BAD_CODE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // Holds the current phase and the cycle index inside it.
  // NOTE: sequential state is written with <= so every flop samples the values
  // from before the edge; a blocking = here would let later statements see
  // already-updated state and turn a register chain into a wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // Advances the phase when the cycle index reaches the phase's last cycle.
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          // An out-of-range code skips the contact phases and only waits out
          // the release gap (or nothing at all when there is no gap).
          state_d = code_ok ? PRESS_ENTRY : AFTER_RELEASE;
        end
      end
      BOUNCE_IN: begin
        if (cnt_q == BOUNCE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = AFTER_HOLD;
          cnt_d   = '0;
        end
      end
      BOUNCE_OUT: begin
        if (cnt_q == BOUNCE_LAST) begin
          state_d = AFTER_RELEASE;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  // Decodes the upcoming phase so that the registered outputs line up with the
  // state they describe (contact for k=0 is visible in the first busy cycle).
  always_comb begin
    contact_d  = 1'b0;
    ready_d    = (state_d == IDLE);
    invalid_d  = accept && !code_ok;
    hold_entry = (state_d == HOLD) && (state_q != HOLD);
    case (state_d)
      BOUNCE_IN:  contact_d = ~cnt_d[0];  // closed on even k
      HOLD:       contact_d = 1'b1;
      BOUNCE_OUT: contact_d = cnt_d[0];   // closed on odd k
      default:    contact_d = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and press bookkeeping
  // ---------------------------------------------------------------------------
  // Keeps contact, ready, invalid and the press counter glitch-free.
  // NOTE: every flop here, counters and the latched code included, is cleared
  // by reset so an abandoned press leaves nothing behind to replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contact_q  <= 1'b0;
      ready_q    <= 1'b1;
      invalid_q  <= 1'b0;
      count_q    <= '0;
      cur_code_q <= '0;
    end else begin
      contact_q <= contact_d;
      ready_q   <= ready_d;
      invalid_q <= invalid_d;
      if (hold_entry) begin
        count_q <= count_q + 8'd1;  // natural 8-bit wrap 255 -> 0
      end
      if (accept) begin
        cur_code_q <= key_code;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Key geometry
  // ---------------------------------------------------------------------------
  // Maps the latched code onto its matrix row and column.
  always_comb begin
    key_row = 2'd0;
    key_col = 2'd0;
    case (cur_code_q)
      4'd0:    begin key_row = 2'd0; key_col = 2'd0; end
      4'd1:    begin key_row = 2'd0; key_col = 2'd1; end
      4'd2:    begin key_row = 2'd0; key_col = 2'd2; end
      4'd3:    begin key_row = 2'd1; key_col = 2'd0; end
      4'd4:    begin key_row = 2'd1; key_col = 2'd1; end
      4'd5:    begin key_row = 2'd1; key_col = 2'd2; end
      4'd6:    begin key_row = 2'd2; key_col = 2'd0; end
      4'd7:    begin key_row = 2'd2; key_col = 2'd1; end
      4'd8:    begin key_row = 2'd2; key_col = 2'd2; end
      4'd9:    begin key_row = 2'd3; key_col = 2'd0; end
      4'd10:   begin key_row = 2'd3; key_col = 2'd1; end
      4'd11:   begin key_row = 2'd3; key_col = 2'd2; end
      // Codes 12..15 never close the contact, so their geometry is moot.
      default: begin key_row = 2'd0; key_col = 2'd0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row sense
  // ---------------------------------------------------------------------------
  // Zero-latency answer to the column drive: only the pressed key's row lights,
  // and only while its column is driven. Other column bits are don't-care.
  always_comb begin
    scanData = '0;
    if (contact_q && columnSel[key_col]) begin
      scanData[key_row] = 1'b1;
    end
  end

  assign key_ready   = ready_q;
  assign busy        = ~ready_q;
  assign invalid     = invalid_q;
  assign press_count = count_q;

endmodule
